// File: rtl/frame_grabber_pkg.sv
// Shared definitions for the frame capture-and-dump engine: state encoding,
// sync header bytes and a constant-foldable clog2.
package frame_grabber_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DUMP     = 2'd3
  } fg_state_e;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/frame_grabber_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// A read of the address being written returns the new data.
module frame_grabber_ram
  import frame_grabber_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/frame_grabber.sv
// Captures one (optionally decimated) frame of the pixel stream into RAM and
// streams it out over a valid/ready byte port behind an optional sync header.
module frame_grabber
  import frame_grabber_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int DECIM     = 1,
  parameter int PIX_W     = 8,
  parameter int DEPTH     = (H_ACTIVE / DECIM) * (V_ACTIVE / DECIM),
  parameter int ADDR_W    = clog2(DEPTH),
  parameter int HEADER_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              cont_mode,
  input  logic              abort,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              line_end,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              short_frame,
  output logic [ADDR_W:0]   captured_count
);

  localparam int XW = clog2(H_ACTIVE) + 1;
  localparam int YW = clog2(V_ACTIVE) + 1;
  localparam int CW = ADDR_W + 1;
  localparam int SW = ADDR_W + 2;
  localparam logic [XW-1:0] X_MASK  = XW'(DECIM - 1);
  localparam logic [YW-1:0] Y_MASK  = YW'(DECIM - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] HDR_C   = (HEADER_EN != 0) ? SW'(2) : '0;

  fg_state_e state, state_next;

  logic [XW-1:0]    x, x_base, x_step;
  logic [YW-1:0]    y, y_base, y_step;
  logic [CW-1:0]    wr_addr, wr_base, wr_step;
  logic [CW-1:0]    rd_addr, rd_next;
  logic [SW-1:0]    seq, total;
  logic             cap_go, keep, ram_we, drop;
  logic             slot_free, load, finish, hdr_phase;
  logic [PIX_W-1:0] rdata_p1;
  logic [7:0]       byte_next;

  // A frame_start (even on the WAIT_SOF cycle) rebases the counters before
  // any same-cycle pixel or line_end is applied.
  always_comb begin
    cap_go  = !abort && ((state == CAPTURE) || ((state == WAIT_SOF) && frame_start));
    x_base  = frame_start ? '0 : x;
    y_base  = frame_start ? '0 : y;
    wr_base = frame_start ? '0 : wr_addr;
    keep    = pix_valid && ((x_base & X_MASK) == '0) && ((y_base & Y_MASK) == '0);
    ram_we  = cap_go && keep && (wr_base < DEPTH_C);
    drop    = cap_go && keep && !(wr_base < DEPTH_C);
    wr_step = ram_we ? wr_base + CW'(1) : wr_base;
    x_step  = x_base;
    y_step  = y_base;
    if (pix_valid && (x_base != '1)) x_step = x_base + XW'(1);
    if (line_end) begin
      x_step = '0;
      if (y_base != '1) y_step = y_base + YW'(1);
    end
  end

  // rd_next is presented to the RAM one cycle early so the byte for the next
  // load is already in rdata_p1 when the output slot frees up.
  always_comb begin
    total     = HDR_C + SW'(captured_count);
    slot_free = !tx_valid || tx_ready;
    load      = (state == DUMP) && !abort && slot_free && (seq != total);
    finish    = (state == DUMP) && !abort && slot_free && (seq == total);
    hdr_phase = seq < HDR_C;
    byte_next = hdr_phase ? (seq[0] ? SYNC1 : SYNC0) : 8'(rdata_p1);
    if ((state != DUMP) || abort) rd_next = '0;
    else if (load && !hdr_phase)  rd_next = rd_addr + CW'(1);
    else                          rd_next = rd_addr;
  end

  frame_grabber_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (PIX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_base[ADDR_W-1:0]),
    .wdata (pix_data),
    .raddr (rd_next[ADDR_W-1:0]),
    .rdata (rdata_p1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (arm) state_next = WAIT_SOF;
      WAIT_SOF: if (frame_start) state_next = frame_end ? DUMP : CAPTURE;
      CAPTURE:  if (frame_end) state_next = DUMP;
      DUMP:     if (finish) state_next = cont_mode ? WAIT_SOF : IDLE;
      default:  state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x              <= '0;
      y              <= '0;
      wr_addr        <= '0;
      rd_addr        <= '0;
      seq            <= '0;
      tx_valid       <= 1'b0;
      tx_data        <= '0;
      done           <= 1'b0;
      overflow       <= 1'b0;
      short_frame    <= 1'b0;
      captured_count <= '0;
    end else begin
      rd_addr <= rd_next;
      done    <= finish;
      if (cap_go) begin
        x       <= x_step;
        y       <= y_step;
        wr_addr <= wr_step;
        if (frame_end) begin
          captured_count <= wr_step;
          if (wr_step < DEPTH_C) short_frame <= 1'b1;
        end
      end
      if (drop) overflow <= 1'b1;
      if ((state == IDLE) && arm && !abort) begin
        overflow    <= 1'b0;
        short_frame <= 1'b0;
      end
      if (state != DUMP) seq <= '0;
      else if (load)     seq <= seq + SW'(1);
      if (abort) tx_valid <= 1'b0;
      else if (load) begin
        tx_valid <= 1'b1;
        tx_data  <= byte_next;
      end else if (tx_ready) tx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_grabber.sv
// Bench for frame_grabber: two instances (full-rate and 2x decimated) share
// randomised stimulus and are compared against a frame-level reference model.
module tb_frame_grabber;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset;
  logic arm, cont_mode, abort, frame_start, frame_end, line_end, pix_valid;
  logic [7:0] pix_data;
  logic tx_ready = 1'b1;

  logic [7:0] a_tx_data, b_tx_data;
  logic a_tx_valid, a_busy, a_done, a_ovf, a_short;
  logic b_tx_valid, b_busy, b_done, b_ovf, b_short;
  logic [4:0] a_cnt;
  logic [2:0] b_cnt;

  always #5 clk = ~clk;

  frame_grabber #(.H_ACTIVE(4), .V_ACTIVE(3), .DECIM(1), .PIX_W(8),
                  .DEPTH(12), .ADDR_W(4), .HEADER_EN(1)) dut_a (
    .clk(clk), .reset(reset), .arm(arm), .cont_mode(cont_mode), .abort(abort),
    .frame_start(frame_start), .frame_end(frame_end), .line_end(line_end),
    .pix_valid(pix_valid), .pix_data(pix_data), .tx_data(a_tx_data),
    .tx_valid(a_tx_valid), .tx_ready(tx_ready), .busy(a_busy), .done(a_done),
    .overflow(a_ovf), .short_frame(a_short), .captured_count(a_cnt));

  frame_grabber #(.H_ACTIVE(4), .V_ACTIVE(3), .DECIM(2), .PIX_W(8),
                  .DEPTH(4), .ADDR_W(2), .HEADER_EN(1)) dut_b (
    .clk(clk), .reset(reset), .arm(arm), .cont_mode(cont_mode), .abort(abort),
    .frame_start(frame_start), .frame_end(frame_end), .line_end(line_end),
    .pix_valid(pix_valid), .pix_data(pix_data), .tx_data(b_tx_data),
    .tx_valid(b_tx_valid), .tx_ready(tx_ready), .busy(b_busy), .done(b_done),
    .overflow(b_ovf), .short_frame(b_short), .captured_count(b_cnt));

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  bq_t q_a, q_b, exp_a, exp_b, c_a, c_b;
  int done_a = 0, done_b = 0, cyc = 0, first_a = 0, last_a = 0, done_lat_a = 0;
  int exp_cnt_a, exp_cnt_b, busy_drops = 0;
  bit exp_ovf_a, exp_ovf_b, exp_short_a, exp_short_b;
  bit stall_a = 0, stall_b = 0, skip_hold = 1, busy_watch = 0, rdy_rand = 0;
  logic [7:0] held_a, held_b;
  logic [7:0] pix_mem [64];

  // Sink-side monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!skip_hold && stall_a) begin
      check("hold_vld_a", 32'(a_tx_valid), 1);
      check("hold_dat_a", 32'(a_tx_data), 32'(held_a));
    end
    if (!skip_hold && stall_b) begin
      check("hold_vld_b", 32'(b_tx_valid), 1);
      check("hold_dat_b", 32'(b_tx_data), 32'(held_b));
    end
    if (a_tx_valid && tx_ready) begin
      if (q_a.size() == 0) first_a = cyc;
      q_a.push_back(a_tx_data);
      last_a = cyc;
    end
    if (b_tx_valid && tx_ready) q_b.push_back(b_tx_data);
    if (a_done) begin done_a++; done_lat_a = cyc - last_a; end
    if (b_done) done_b++;
    if (busy_watch && !a_busy) busy_drops++;
    stall_a   = a_tx_valid && !tx_ready;
    stall_b   = b_tx_valid && !tx_ready;
    held_a    = a_tx_data;
    held_b    = b_tx_data;
    skip_hold = abort || reset;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    arm = 0; abort = 0; frame_start = 0; frame_end = 0; line_end = 0; pix_valid = 0;
    pix_data = 8'($urandom);
    tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic fill_pix(input bit rnd);
    for (int i = 0; i < 64; i++) pix_mem[i] = rnd ? 8'($urandom) : 8'(i);
  endtask

  // Frame-level model: pixel i sits at column i%4 of line i/4.
  task automatic build_exp(input int npix);
    int na, nb;
    na = 0; nb = 0; exp_ovf_a = 0; exp_ovf_b = 0;
    exp_a = {8'hA5, 8'h5A};
    exp_b = {8'hA5, 8'h5A};
    for (int i = 0; i < npix; i++) begin
      if (na < 12) begin exp_a.push_back(pix_mem[i]); na++; end
      else exp_ovf_a = 1;
      if (((i / 4) % 2 == 0) && ((i % 4) % 2 == 0)) begin
        if (nb < 4) begin exp_b.push_back(pix_mem[i]); nb++; end
        else exp_ovf_b = 1;
      end
    end
    exp_cnt_a = na; exp_cnt_b = nb;
    exp_short_a = (na < 12); exp_short_b = (nb < 4);
  endtask

  task automatic send_frame(input int npix, input bit fe_same);
    next_cycle();
    frame_start = 1;
    if ($urandom_range(0, 1) == 1) next_cycle();
    for (int i = 0; i < npix; i++) begin
      if (i != 0) begin
        next_cycle();
        if ($urandom_range(0, 3) == 0) next_cycle();
      end
      pix_valid = 1;
      pix_data  = pix_mem[i];
      if (i % 4 == 3) begin
        if ($urandom_range(0, 1) == 1) line_end = 1;
        else begin next_cycle(); line_end = 1; end
      end
    end
    if (!fe_same) next_cycle();
    frame_end = 1;
    next_cycle();
  endtask

  task automatic start_test();
    q_a.delete(); q_b.delete();
    done_a = 0; done_b = 0;
  endtask

  task automatic wait_done(input int na, input int nb);
    for (int k = 0; k < 2000 && (done_a < na || done_b < nb); k++) next_cycle();
  endtask

  task automatic cmp_q(input string tag, input bq_t got, input bq_t exp);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask

  task automatic check_frame(input string tag);
    wait_done(1, 1);
    repeat (3) next_cycle();
    cmp_q({tag, "_a"}, q_a, exp_a);
    cmp_q({tag, "_b"}, q_b, exp_b);
    check({tag, "_cnt_a"}, 32'(a_cnt), exp_cnt_a);
    check({tag, "_cnt_b"}, 32'(b_cnt), exp_cnt_b);
    check({tag, "_ovf_a"}, 32'(a_ovf), 32'(exp_ovf_a));
    check({tag, "_ovf_b"}, 32'(b_ovf), 32'(exp_ovf_b));
    check({tag, "_short_a"}, 32'(a_short), 32'(exp_short_a));
    check({tag, "_short_b"}, 32'(b_short), 32'(exp_short_b));
    check({tag, "_done_a"}, done_a, 1);
    check({tag, "_done_b"}, done_b, 1);
    check({tag, "_busy_a"}, 32'(a_busy), 0);
    check({tag, "_busy_b"}, 32'(b_busy), 0);
  endtask

  task automatic run_frame(input string tag, input int npix, input bit fe_same, input bit rnd);
    start_test();
    fill_pix(rnd);
    build_exp(npix);
    next_cycle();
    arm = 1;
    send_frame(npix, fe_same);
    check_frame(tag);
  endtask

  initial begin
    reset = 1; arm = 0; cont_mode = 0; abort = 0; frame_start = 0; frame_end = 0;
    line_end = 0; pix_valid = 0; pix_data = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(a_tx_valid), 0);
    check("rst_data", 32'(a_tx_data), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_done", 32'(a_done), 0);
    check("rst_ovf", 32'(a_ovf), 0);
    check("rst_short", 32'(a_short), 0);
    check("rst_cnt", 32'(a_cnt), 0);
    check("rst_busy_b", 32'(b_busy), 0);
    reset = 0;

    // Ordered 0x00..0x0B frame, sink always ready: contiguous dump.
    run_frame("basic", 12, 0, 0);
    check("basic_contig", last_a - first_a, 13);
    check("basic_done_lat", done_lat_a, 1);

    // Extra lines overflow both the full-rate and the decimated store.
    run_frame("ovf", 20, 0, 0);
    run_frame("short", 5, 1, 1);

    rdy_rand = 1;
    for (int t = 0; t < 5; t++)
      run_frame($sformatf("rand%0d", t), $urandom_range(1, 24), 1'($urandom_range(0, 1)), 1);
    rdy_rand = 0;

    // Continuous mode: frame 2 lands during the dump and must be ignored.
    start_test();
    cont_mode = 1;
    fill_pix(1);
    build_exp(12);
    c_a = exp_a; c_b = exp_b;
    next_cycle();
    arm = 1;
    next_cycle();
    busy_watch = 1;
    send_frame(12, 0);
    fill_pix(1);
    send_frame(12, 0);
    wait_done(1, 1);
    fill_pix(1);
    build_exp(12);
    c_a = {c_a, exp_a}; c_b = {c_b, exp_b};
    send_frame(12, 0);
    wait_done(2, 2);
    repeat (2) next_cycle();
    busy_watch = 0;
    cmp_q("cont_a", q_a, c_a);
    cmp_q("cont_b", q_b, c_b);
    check("cont_done_a", done_a, 2);
    check("cont_busy_drops", busy_drops, 0);
    check("cont_busy_wait", 32'(a_busy), 1);
    cont_mode = 0;
    abort = 1;
    next_cycle();
    check("cont_abort_busy", 32'(a_busy), 0);

    // Abort mid-dump, then a normal capture.
    start_test();
    fill_pix(0);
    next_cycle();
    arm = 1;
    send_frame(12, 0);
    for (int k = 0; k < 200 && q_a.size() < 3; k++) next_cycle();
    abort = 1;
    next_cycle();
    check("abort_valid", 32'(a_tx_valid), 0);
    check("abort_busy", 32'(a_busy), 0);
    repeat (4) next_cycle();
    check("abort_done", done_a, 0);
    check("abort_bytes", q_a.size(), 4);
    if (q_a.size() >= 4) check("abort_byte3", 32'(q_a[3]), 32'h01);
    run_frame("after_abort", 12, 1, 1);

    // Asynchronous reset mid-dump drops tx_valid without a clock edge.
    start_test();
    fill_pix(1);
    next_cycle();
    arm = 1;
    send_frame(12, 0);
    for (int k = 0; k < 200 && q_a.size() < 2; k++) next_cycle();
    #2;
    reset = 1;
    #1;
    check("areset_valid", 32'(a_tx_valid), 0);
    check("areset_busy", 32'(a_busy), 0);
    check("areset_cnt", 32'(a_cnt), 0);
    #1;
    reset = 0;
    next_cycle();
    check("areset_idle", 32'(a_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
